// File: rtl/wbm_cmd_master.sv
// Single-outstanding Wishbone classic master: turns one command handshake into one
// bus transfer and reports completion, bus error or timeout as a one-cycle response.
module wbm_cmd_master #(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int BUS_ADDR_WIDTH = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,

   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic                        cmd_we_i,
   input  logic [BUS_ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [BUS_DATA_WIDTH-1:0]   cmd_dat_i,
   input  logic [BUS_DATA_WIDTH/8-1:0] cmd_sel_i,

   output logic                        rsp_valid_o,
   output logic [BUS_DATA_WIDTH-1:0]   rsp_dat_o,
   output logic                        rsp_err_o,
   output logic                        rsp_timeout_o,

   output logic                        wbm_cyc_o,
   output logic                        wbm_stb_o,
   output logic                        wbm_we_o,
   output logic [BUS_ADDR_WIDTH-1:0]   wbm_adr_o,
   output logic [BUS_DATA_WIDTH-1:0]   wbm_dat_o,
   output logic [BUS_DATA_WIDTH/8-1:0] wbm_sel_o,
   input  logic [BUS_DATA_WIDTH-1:0]   wbm_dat_i,
   input  logic                        wbm_ack_i,
   input  logic                        wbm_err_i
);

   localparam int SEL_W = BUS_DATA_WIDTH / 8;
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // Counter holds the number of silent BUS cycles already elapsed, so the limit
   // is hit while the counter still reads one less than TIMEOUT_CYCLES.
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUS,
      ST_RECOVER
   } state_e;

   state_e                    state_q, state_d;
   logic                      cmd_ready_q, cmd_ready_d;
   logic                      cyc_q, cyc_d;
   logic                      we_q, we_d;
   logic [BUS_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [BUS_DATA_WIDTH-1:0] dat_q, dat_d;
   logic [SEL_W-1:0]          sel_q, sel_d;
   logic                      rsp_valid_q, rsp_valid_d;
   logic [BUS_DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
   logic                      rsp_err_q, rsp_err_d;
   logic                      rsp_timeout_q, rsp_timeout_d;
   logic [CNT_W-1:0]          tmo_cnt_q, tmo_cnt_d;

   logic                      bus_done;
   logic                      tmo_hit;

   // Read data is only returned for a clean read ack; writes and errors report zero.
   function automatic logic [BUS_DATA_WIDTH-1:0] rsp_data(
      input logic                      we,
      input logic                      ack,
      input logic                      err,
      input logic [BUS_DATA_WIDTH-1:0] rdata
   );
      return (ack && !err && !we) ? rdata : '0;
   endfunction

   assign bus_done = wbm_ack_i | wbm_err_i;
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CNT_LAST);

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = 1'b0;
      cyc_d         = cyc_q;
      we_d          = we_q;
      adr_d         = adr_q;
      dat_d         = dat_q;
      sel_d         = sel_q;
      rsp_valid_d   = 1'b0;
      rsp_dat_d     = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      tmo_cnt_d     = tmo_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid_i && cmd_ready_q) begin
               state_d     = ST_BUS;
               cmd_ready_d = 1'b0;
               cyc_d       = 1'b1;
               we_d        = cmd_we_i;
               adr_d       = cmd_adr_i;
               dat_d       = cmd_dat_i;
               sel_d       = cmd_sel_i;
               tmo_cnt_d   = '0;
            end
         end

         ST_BUS: begin
            if (bus_done) begin
               state_d     = ST_RECOVER;
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = wbm_err_i;
               rsp_dat_d   = rsp_data(we_q, wbm_ack_i, wbm_err_i, wbm_dat_i);
            end else if (tmo_hit) begin
               state_d       = ST_RECOVER;
               cyc_d         = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end

         ST_RECOVER: begin
            // A slave may still be holding ack/err from the finished transfer.
            if (!bus_done) begin
               state_d     = ST_IDLE;
               cmd_ready_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b0;
         cyc_q         <= 1'b0;
         we_q          <= 1'b0;
         adr_q         <= '0;
         dat_q         <= '0;
         sel_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_dat_q     <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         tmo_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         cyc_q         <= cyc_d;
         we_q          <= we_d;
         adr_q         <= adr_d;
         dat_q         <= dat_d;
         sel_q         <= sel_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_dat_q     <= rsp_dat_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         tmo_cnt_q     <= tmo_cnt_d;
      end
   end

   assign cmd_ready_o   = cmd_ready_q;
   assign wbm_cyc_o     = cyc_q;
   assign wbm_stb_o     = cyc_q;
   assign wbm_we_o      = we_q;
   assign wbm_adr_o     = adr_q;
   assign wbm_dat_o     = dat_q;
   assign wbm_sel_o     = sel_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_dat_o     = rsp_dat_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_wbm_cmd_master.sv
// Bench for wbm_cmd_master: table of bus transfers with a response scoreboard,
// plus hand-built sequences for timeout, reset mid-transfer and back-to-back commands.
module tb_wbm_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
   logic [7:0]  cmd_adr_i;
   logic [31:0] cmd_dat_i;
   logic [3:0]  cmd_sel_i;
   logic        rsp_valid_o, rsp_err_o, rsp_timeout_o;
   logic [31:0] rsp_dat_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [7:0]  wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i, wbm_err_i;

   always #5 clk = ~clk;

   wbm_cmd_master #(
      .BUS_DATA_WIDTH(32),
      .BUS_ADDR_WIDTH(8),
      .TIMEOUT_CYCLES(255)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_we_i     (cmd_we_i),
      .cmd_adr_i    (cmd_adr_i),
      .cmd_dat_i    (cmd_dat_i),
      .cmd_sel_i    (cmd_sel_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_dat_o    (rsp_dat_o),
      .rsp_err_o    (rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o),
      .wbm_cyc_o    (wbm_cyc_o),
      .wbm_stb_o    (wbm_stb_o),
      .wbm_we_o     (wbm_we_o),
      .wbm_adr_o    (wbm_adr_o),
      .wbm_dat_o    (wbm_dat_o),
      .wbm_sel_o    (wbm_sel_o),
      .wbm_dat_i    (wbm_dat_i),
      .wbm_ack_i    (wbm_ack_i),
      .wbm_err_i    (wbm_err_i)
   );

   typedef struct {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          delay;
      int          hold;
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] exp_dat;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      logic        err;
      logic        to;
   } rsp_t;

   rsp_t sb_q[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   rsp_cnt  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // Response monitor: every pulse must match the oldest scoreboard entry.
   always @(negedge clk) begin : mon
      rsp_t e;
      if (rsp_valid_o === 1'b1) begin
         rsp_cnt++;
         if (sb_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid_o), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_dat", rsp_dat_o, e.dat);
            chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e.to));
         end
      end else if (!rst) begin
         chk("rsp_flags_unqualified", 32'({rsp_err_o, rsp_timeout_o}), 32'd0);
      end
   end

   task automatic wait_idle();
      int w = 0;
      while (cmd_ready_o !== 1'b1 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("idle_wait", 32'(cmd_ready_o), 32'd1);
   endtask

   task automatic issue(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
      int w = 0;
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      cmd_sel_i   = sel;
      while (cmd_ready_o !== 1'b1 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("accept_wait", 32'(cmd_ready_o), 32'd1);
      @(posedge clk); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   c0 = rsp_cnt;
      rsp_t e;
      e.dat = v.exp_dat;
      e.err = v.exp_err;
      e.to  = 1'b0;
      sb_q.push_back(e);
      issue(v.we, v.adr, v.dat, v.sel);
      @(negedge clk);
      chk({tag, "_cyc_stb"}, 32'({wbm_cyc_o, wbm_stb_o}), 32'd3);
      chk({tag, "_we"},  32'(wbm_we_o), 32'(v.we));
      chk({tag, "_adr"}, 32'(wbm_adr_o), 32'(v.adr));
      chk({tag, "_dat"}, wbm_dat_o, v.dat);
      chk({tag, "_sel"}, 32'(wbm_sel_o), 32'(v.sel));
      repeat (v.delay) begin
         @(negedge clk);
         chk({tag, "_stb_wait"}, 32'(wbm_stb_o), 32'd1);
         chk({tag, "_adr_stable"}, 32'(wbm_adr_o), 32'(v.adr));
      end
      wbm_ack_i = v.ack;
      wbm_err_i = v.err;
      wbm_dat_i = v.rdata;
      repeat (v.hold) begin
         @(negedge clk);
         chk({tag, "_ready_low_ack"}, 32'(cmd_ready_o), 32'd0);
      end
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = '0;
      wait_idle();
      chk({tag, "_one_rsp"}, 32'(rsp_cnt - c0), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int   c0;
      int   n;
      int   w;
      rsp_t e;

      //        we    adr    dat           sel  dly hold ack  err  rdata         exp_dat       exp_err
      vecs[0] = '{1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 2, 1, 1'b1, 1'b0, 32'h0BADF00D, 32'h00000000, 1'b0};
      vecs[1] = '{1'b0, 8'h00, 32'h00000000, 4'hF, 0, 3, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b0};
      vecs[2] = '{1'b0, 8'h0F, 32'h00000000, 4'hF, 0, 1, 1'b1, 1'b1, 32'hAAAA5555, 32'h00000000, 1'b1};
      vecs[3] = '{1'b1, 8'h10, 32'h87654321, 4'hF, 1, 1, 1'b0, 1'b1, 32'h00000000, 32'h00000000, 1'b1};
      vecs[4] = '{1'b0, 8'h20, 32'h00000000, 4'h3, 4, 2, 1'b1, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
      vecs[5] = '{1'b0, 8'h30, 32'h00000000, 4'hC, 0, 1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[6] = '{1'b1, 8'hFC, 32'h01020304, 4'h5, 0, 1, 1'b1, 1'b0, 32'h55555555, 32'h00000000, 1'b0};

      rst = 1'b1;
      cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
      wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cyc_stb_we", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o}), 32'd0);
      chk("rst_adr", 32'(wbm_adr_o), 32'd0);
      chk("rst_dat", wbm_dat_o, 32'd0);
      chk("rst_sel", 32'(wbm_sel_o), 32'd0);
      chk("rst_rsp", 32'({rsp_valid_o, rsp_err_o, rsp_timeout_o}), 32'd0);
      chk("rst_rsp_dat", rsp_dat_o, 32'd0);
      chk("rst_ready", 32'(cmd_ready_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", 32'(cmd_ready_o), 32'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Silent slave: STB must stay up for exactly the timeout limit.
      c0 = rsp_cnt;
      e.dat = '0; e.err = 1'b1; e.to = 1'b1;
      sb_q.push_back(e);
      issue(1'b0, 8'h40, 32'h0, 4'hF);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (wbm_stb_o === 1'b1) n++;
         else break;
      end
      chk("tmo_stb_cycles", 32'(n), 32'd255);
      wait_idle();
      chk("tmo_one_rsp", 32'(rsp_cnt - c0), 32'd1);

      // One-cycle reset in the middle of a transfer.
      c0 = rsp_cnt;
      issue(1'b1, 8'h60, 32'h5555AAAA, 4'hF);
      @(negedge clk);
      chk("midrst_cyc_before", 32'(wbm_cyc_o), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_cyc_stb", 32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
      chk("midrst_ready", 32'(cmd_ready_o), 32'd0);
      chk("midrst_adr", 32'(wbm_adr_o), 32'd0);
      @(negedge clk);
      chk("midrst_ready_rise", 32'(cmd_ready_o), 32'd1);
      repeat (3) @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_cnt - c0), 32'd0);
      @(posedge clk); #1;
      run_vec(vecs[1], "after_rst");

      // cmd_valid held high with a new address while the first transfer runs.
      c0 = rsp_cnt;
      e.dat = '0; e.err = 1'b0; e.to = 1'b0;
      sb_q.push_back(e);
      cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 8'h50;
      cmd_dat_i = 32'h11111111; cmd_sel_i = 4'hF;
      @(posedge clk); #1;
      cmd_adr_i = 8'h51;
      cmd_dat_i = 32'h22222222;
      @(negedge clk);
      chk("b2b_first_adr", 32'(wbm_adr_o), 32'h50);
      chk("b2b_first_dat", wbm_dat_o, 32'h11111111);
      @(negedge clk);
      chk("b2b_adr_hold", 32'(wbm_adr_o), 32'h50);
      wbm_ack_i = 1'b1;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      w = 0;
      while (cmd_ready_o !== 1'b1 && w < 20) begin
         @(negedge clk);
         chk("b2b_adr_not_stored", 32'(wbm_adr_o), 32'h50);
         w++;
      end
      chk("b2b_second_ready", 32'(cmd_ready_o), 32'd1);
      sb_q.push_back(e);
      @(negedge clk);
      cmd_valid_i = 1'b0;
      chk("b2b_second_cyc", 32'(wbm_cyc_o), 32'd1);
      chk("b2b_second_adr", 32'(wbm_adr_o), 32'h51);
      chk("b2b_second_dat", wbm_dat_o, 32'h22222222);
      wbm_ack_i = 1'b1;
      @(negedge clk);
      wbm_ack_i = 1'b0;
      wait_idle();
      chk("b2b_two_rsp", 32'(rsp_cnt - c0), 32'd2);

      repeat (5) @(posedge clk);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wbm_cmd_master.md
WBM_CMD_MASTER -- requirements
Module: wbm_cmd_master

Interface
REQ-001 The block SHALL have parameter BUS_DATA_WIDTH, default 32, giving the data width; only multiples of 8 up to 64 are legal.
REQ-002 The block SHALL have parameter BUS_ADDR_WIDTH, default 8, giving the address width (4, 8, 16 or 32).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of STB-high cycles per transfer; 0 disables the timeout.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 wb_rst_i  in  1  synchronous active-high reset.
REQ-007 cmd_valid_i  in  1  command request.
REQ-008 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-009 cmd_we_i  in  1  1 = write, 0 = read.
REQ-010 cmd_adr_i  in  BUS_ADDR_WIDTH  target address.
REQ-011 cmd_dat_i  in  BUS_DATA_WIDTH  write data.
REQ-012 cmd_sel_i  in  BUS_DATA_WIDTH/8  byte enables.
REQ-013 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-014 rsp_dat_o  out  BUS_DATA_WIDTH  read data.
REQ-015 rsp_err_o  out  1  bus error or timeout; qualified by rsp_valid_o.
REQ-016 rsp_timeout_o  out  1  timeout; qualified by rsp_valid_o.
REQ-017 wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle, strobe and write enable.
REQ-018 wbm_adr_o, wbm_dat_o, wbm_sel_o  out  BUS_ADDR_WIDTH, BUS_DATA_WIDTH, BUS_DATA_WIDTH/8  Wishbone address, data and byte select.
REQ-019 wbm_dat_i, wbm_ack_i, wbm_err_i  in  BUS_DATA_WIDTH, 1, 1  Wishbone slave data, acknowledge and error.

Function
REQ-020 The FSM SHALL have three states:
- IDLE
- BUS: CYC and STB high.
- RECOVER: CYC and STB low, waiting for wbm_ack_i and wbm_err_i both low.
REQ-021 cmd_ready_o SHALL be high only in IDLE and SHALL be registered.
REQ-022 In the acceptance cycle (cmd_valid_i & cmd_ready_o), the block SHALL register we/adr/dat/sel onto the wbm_* outputs and enter BUS; CYC and STB go high on the next cycle.
REQ-023 The wbm_* address, data, select and we outputs SHALL remain stable for the whole of BUS.
REQ-024 In BUS, a cycle with wbm_ack_i or wbm_err_i high SHALL end the transfer:
- CYC and STB low on the next cycle.
- rsp_valid_o high on the next cycle for exactly one cycle.
- State moves to RECOVER.
REQ-025 On a read ending with ack, rsp_dat_o SHALL equal wbm_dat_i sampled in the ack cycle.
REQ-026 On a write, or on any error or timeout, rsp_dat_o SHALL be 0.
REQ-027 If wbm_ack_i and wbm_err_i are high together, error SHALL win: rsp_err_o=1 and rsp_dat_o=0.
REQ-028 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack or err.
- If the counter reaches TIMEOUT_CYCLES, the transfer ends as in REQ-024 with rsp_err_o=1 and rsp_timeout_o=1.
- Ack or err in the same cycle the limit is reached takes precedence over timeout.
REQ-029 RECOVER SHALL return to IDLE in the first cycle in which wbm_ack_i=0 and wbm_err_i=0; the minimum RECOVER time is 1 cycle.
REQ-030 A command presented while cmd_ready_o=0 SHALL be ignored and SHALL NOT be stored.
REQ-031 Minimum spacing SHALL be 4 cycles from accept to next accept (accept, BUS, RECOVER, IDLE) with a single-cycle ack.
REQ-032 rsp_err_o and rsp_timeout_o SHALL be 0 whenever rsp_valid_o=0.

Reset
REQ-033 While wb_rst_i=1, the block SHALL force state IDLE and drive these outputs to the values listed:
- wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0.
- wbm_adr_o, wbm_dat_o, wbm_sel_o = 0.
- rsp_valid_o=0, rsp_err_o=0, rsp_timeout_o=0, rsp_dat_o=0.
- cmd_ready_o=0.
REQ-034 cmd_ready_o SHALL rise in the first cycle after wb_rst_i falls.
REQ-035 Reset asserted during BUS or RECOVER SHALL drop CYC and STB on the next edge, produce no rsp_valid_o pulse and discard the command.

Verification
REQ-036 Write adr=0x04 dat=0xDEADBEEF sel=0xF, slave acks 2 cycles after STB rises -> bus shows the same values, rsp_valid_o pulses once with err=0 and dat=0.
REQ-037 Read adr=0x00, slave returns 0x12345678 with ack held high for 3 cycles -> rsp_dat_o=0x12345678, one pulse only, cmd_ready_o stays low until ack falls.
REQ-038 Read adr=0x0F with wbm_ack_i and wbm_err_i high together -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
REQ-039 TIMEOUT_CYCLES=255, slave silent -> STB high for exactly 255 cycles, then rsp_err_o=1 and rsp_timeout_o=1, then IDLE.
REQ-040 wb_rst_i pulsed for 1 cycle mid-BUS -> CYC/STB low next edge, no response, the next command completes normally.
REQ-041 cmd_valid_i held high with a changing address during BUS -> only the first command is issued, and the second is accepted only after return to IDLE.
